dram_writer_burst: RTL

DRAM_WRITER_BURST -- requirements
Module: dram_writer_burst

---
 rtl/dram_writer_burst.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dram_writer_burst.sv
// Streams DATA beats to memory as AXI4 INCR write bursts.
// One config request is one transfer; DONE pulses once all B responses return.
module dram_writer_burst #(
  parameter int DATA_W          = 64,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  output logic [31:0]         M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [3:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  output logic                M_AXI_WLAST,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  input  logic                CONFIG_VALID,
  output logic                CONFIG_READY,
  input  logic [31:0]         CONFIG_START_ADDR,
  input  logic [31:0]         CONFIG_NBYTES,
  input  logic [DATA_W-1:0]   DATA,
  input  logic                DATA_VALID,
  output logic                DATA_READY,
  output logic                DONE,
  output logic                ERROR
);

  localparam int          BEAT_BYTES = DATA_W / 8;
  localparam int          SHIFT      = $clog2(BEAT_BYTES);
  localparam logic [31:0] STRIDE     = 32'(BURST_LEN * BEAT_BYTES);
  localparam logic [31:0] BLEN       = 32'(BURST_LEN);
  localparam logic [31:0] MAXO       = 32'(MAX_OUTSTANDING);
  localparam logic [4:0]  LAST_IDX   = 5'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] aw_addr;
  logic [31:0] aw_rem;
  logic [31:0] aw_sent;
  logic [31:0] b_recv;
  logic [31:0] w_burst;
  logic [31:0] w_rem;
  logic [4:0]  w_beat;
  logic        aw_valid;
  logic        err;

  logic [31:0] cfg_beats;
  logic [31:0] aw_cur;
  logic        w_ok;
  logic        w_last;
  logic        w_fire;
  logic        aw_fire;
  logic        b_fire;
  logic        cfg_fire;
  logic        all_done;

  assign cfg_beats = CONFIG_NBYTES >> SHIFT;
  assign aw_cur    = (aw_rem > BLEN) ? BLEN : aw_rem;
  assign w_ok      = (w_burst < aw_sent);
  assign w_last    = (w_beat == LAST_IDX) || (w_rem == 32'd1);
  assign w_fire    = (state == RUN) && DATA_VALID
                   && M_AXI_WREADY && w_ok;
  assign aw_fire   = aw_valid && M_AXI_AWREADY;
  assign b_fire    = (state == RUN) && M_AXI_BVALID;
  assign cfg_fire  = (state == IDLE) && CONFIG_VALID;
  assign all_done  = (aw_rem == 32'd0) && (w_rem == 32'd0)
                   && (b_recv == aw_sent);

  assign M_AXI_AWADDR  = aw_addr;
  assign M_AXI_AWVALID = aw_valid;
  assign M_AXI_AWLEN   = 4'(aw_cur - 32'd1);
  assign M_AXI_AWSIZE  = 3'(SHIFT);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WDATA   = DATA;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = w_last;
  assign M_AXI_BREADY  = 1'b1;
  assign ERROR         = err;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (CONFIG_VALID)
              state_nxt = (cfg_beats == 32'd0) ? FIN : RUN;
      RUN:  if (all_done) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    CONFIG_READY = (state == IDLE);
    DONE         = (state == FIN);
    M_AXI_WVALID = (state == RUN) && DATA_VALID && w_ok;
    DATA_READY   = (state == RUN) && M_AXI_WREADY && w_ok;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_addr  <= '0;
      aw_rem   <= '0;
      aw_sent  <= '0;
      b_recv   <= '0;
      w_burst  <= '0;
      w_rem    <= '0;
      w_beat   <= '0;
      aw_valid <= 1'b0;
      err      <= 1'b0;
    end else if (cfg_fire) begin
      aw_addr  <= CONFIG_START_ADDR;
      aw_rem   <= cfg_beats;
      w_rem    <= cfg_beats;
      aw_sent  <= '0;
      b_recv   <= '0;
      w_burst  <= '0;
      w_beat   <= '0;
      aw_valid <= 1'b0;
      err      <= 1'b0;
    end else if (state == RUN) begin
      // Issue gate uses registered counts; a same-cycle B only loosens it.
      if (aw_fire) begin
        aw_valid <= 1'b0;
        aw_addr  <= aw_addr + STRIDE;
        aw_rem   <= aw_rem - aw_cur;
        aw_sent  <= aw_sent + 32'd1;
      end else if (!aw_valid && aw_rem != 32'd0
                   && (aw_sent - b_recv) < MAXO) begin
        aw_valid <= 1'b1;
      end
      if (w_fire) begin
        w_rem <= w_rem - 32'd1;
        if (w_last) begin
          w_beat  <= '0;
          w_burst <= w_burst + 32'd1;
        end else begin
          w_beat  <= w_beat + 5'd1;
        end
      end
      if (b_fire) begin
        b_recv <= b_recv + 32'd1;
        if (M_AXI_BRESP != 2'b00) err <= 1'b1;
      end
    end
  end

endmodule
